// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared FP op codes, constants, flag indices and operand classification
package fp_pkg;

  localparam logic [2:0] OP_FADD  = 3'b000;
  localparam logic [2:0] OP_FSUB  = 3'b001;
  localparam logic [2:0] OP_FMUL  = 3'b010;
  localparam logic [2:0] OP_FMIN  = 3'b011;
  localparam logic [2:0] OP_FMAX  = 3'b100;
  localparam logic [2:0] OP_FEQ   = 3'b101;
  localparam logic [2:0] OP_FLT   = 3'b110;
  localparam logic [2:0] OP_FSGNJ = 3'b111;

  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] INF       = 64'h7FF0_0000_0000_0000;

  localparam int NV = 4;
  localparam int DZ = 3;
  localparam int OF = 2;
  localparam int UF = 1;
  localparam int NX = 0;

  typedef struct packed {
    logic isnan;
    logic issnan;
    logic isinf;
    logic iszero;
  } fp_class_t;

  typedef struct packed {
    logic [63:0] val;
    logic [4:0]  flags;
  } fp_res_t;

  // Subnormals classify as zero because the datapath flushes them on input.
  function automatic fp_class_t fp_classify(input logic [63:0] x);
    fp_class_t c;
    c.isnan  = (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
    c.issnan = c.isnan && !x[51];
    c.isinf  = (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
    c.iszero = (x[62:52] == 11'd0);
    return c;
  endfunction

  function automatic logic [63:0] fp_flush(input logic [63:0] x);
    return (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
  endfunction

endpackage

// File: rtl/fp_dp_alu.sv
// rtl/fp_dp_alu.sv - combinational binary64 FPU: add/sub/mul, min/max, compares, sign inject
module fp_dp_alu
  import fp_pkg::*;
(
  input  logic [63:0] fop1,
  input  logic [63:0] fop2,
  input  logic [2:0]  funct3,
  output logic [63:0] fresult,
  output logic [4:0]  fflags
);

  // m holds 1.52 significand in [55:3] plus guard/round/sticky in [2:0].
  function automatic fp_res_t round_pack(input logic sign, input logic signed [12:0] exp_in,
                                         input logic [55:0] m);
    fp_res_t r;
    logic [53:0] rm;
    logic signed [12:0] e;
    logic up;
    up = m[2] & (m[3] | m[1] | m[0]);
    rm = {1'b0, m[55:3]} + {53'd0, up};
    e  = exp_in;
    if (rm[53]) begin
      rm = rm >> 1;
      e  = e + 13'sd1;
    end
    r.flags     = 5'd0;
    r.flags[NX] = |m[2:0];
    if (e >= 13'sd2047) begin
      r.val       = {sign, INF[62:0]};
      r.flags[OF] = 1'b1;
      r.flags[NX] = 1'b1;
    end else if (e <= 13'sd0) begin
      r.val       = {sign, 63'd0};
      r.flags[UF] = 1'b1;
      r.flags[NX] = 1'b1;
    end else begin
      r.val = {sign, e[10:0], rm[51:0]};
    end
    return r;
  endfunction

  // b arrives with its sign already flipped for subtraction.
  function automatic fp_res_t fp_add(input logic [63:0] a, input logic [63:0] b,
                                     input fp_class_t ca, input fp_class_t cb);
    fp_res_t r;
    logic a_big, sx;
    logic [10:0] ex, ey, d;
    logic [52:0] mx, my;
    logic [5:0] dd, lsh;
    logic [111:0] sh;
    logic [55:0] ys, m;
    logic [56:0] s;
    logic signed [12:0] e;
    int lead;
    r.val   = CANON_NAN;
    r.flags = 5'd0;
    if (ca.isnan || cb.isnan) begin
      r.flags[NV] = ca.issnan | cb.issnan;
    end else if (ca.isinf && cb.isinf) begin
      if (a[63] != b[63]) r.flags[NV] = 1'b1;
      else                r.val = {a[63], INF[62:0]};
    end else if (ca.isinf) begin
      r.val = {a[63], INF[62:0]};
    end else if (cb.isinf) begin
      r.val = {b[63], INF[62:0]};
    end else if (ca.iszero && cb.iszero) begin
      r.val = {a[63] & b[63], 63'd0};
    end else if (ca.iszero) begin
      r.val = b;
    end else if (cb.iszero) begin
      r.val = a;
    end else begin
      a_big = a[62:0] >= b[62:0];
      sx    = a_big ? a[63] : b[63];
      ex    = a_big ? a[62:52] : b[62:52];
      ey    = a_big ? b[62:52] : a[62:52];
      mx    = {1'b1, a_big ? a[51:0] : b[51:0]};
      my    = {1'b1, a_big ? b[51:0] : a[51:0]};
      d     = ex - ey;
      dd    = (d > 11'd63) ? 6'd63 : d[5:0];
      sh    = {my, 59'd0} >> dd;
      ys    = sh[111:56] | {55'd0, |sh[55:0]};
      if (a[63] == b[63]) s = {1'b0, mx, 3'b000} + {1'b0, ys};
      else                s = {1'b0, mx, 3'b000} - {1'b0, ys};
      if (s == 57'd0) begin
        r.val = 64'd0;
      end else begin
        lead = 0;
        for (int i = 0; i < 57; i++) if (s[i]) lead = i;
        if (lead == 56) begin
          m = {s[56:2], s[1] | s[0]};
          e = $signed({2'b00, ex}) + 13'sd1;
        end else begin
          lsh = 6'(55 - lead);
          m   = s[55:0] << lsh;
          e   = $signed({2'b00, ex}) - $signed({7'd0, lsh});
        end
        r = round_pack(sx, e, m);
      end
    end
    return r;
  endfunction

  function automatic fp_res_t fp_mul(input logic [63:0] a, input logic [63:0] b,
                                     input fp_class_t ca, input fp_class_t cb);
    fp_res_t r;
    logic sp;
    logic [105:0] p;
    logic [55:0] m;
    logic signed [12:0] e;
    sp      = a[63] ^ b[63];
    r.val   = CANON_NAN;
    r.flags = 5'd0;
    if (ca.isnan || cb.isnan) begin
      r.flags[NV] = ca.issnan | cb.issnan;
    end else if ((ca.isinf && cb.iszero) || (ca.iszero && cb.isinf)) begin
      r.flags[NV] = 1'b1;
    end else if (ca.isinf || cb.isinf) begin
      r.val = {sp, INF[62:0]};
    end else if (ca.iszero || cb.iszero) begin
      r.val = {sp, 63'd0};
    end else begin
      p = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
      e = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - 13'sd1023;
      if (p[105]) begin
        m = {p[105:51], |p[50:0]};
        e = e + 13'sd1;
      end else begin
        m = {p[104:50], |p[49:0]};
      end
      r = round_pack(sp, e, m);
    end
    return r;
  endfunction

  fp_class_t   ca, cb;
  logic [63:0] fa, fb;
  fp_res_t     add_res, mul_res;
  logic        any_nan, any_snan, both_zero, mag_lt_ab, mag_lt_ba, a_below, feq, flt;

  assign fa      = fp_flush(fop1);
  assign fb      = fp_flush(fop2);
  assign ca      = fp_classify(fop1);
  assign cb      = fp_classify(fop2);
  assign add_res = fp_add(fa, {fb[63] ^ (funct3 == OP_FSUB), fb[62:0]}, ca, cb);
  assign mul_res = fp_mul(fa, fb, ca, cb);

  assign any_nan   = ca.isnan | cb.isnan;
  assign any_snan  = ca.issnan | cb.issnan;
  assign both_zero = ca.iszero & cb.iszero;
  assign mag_lt_ab = fa[62:0] < fb[62:0];
  assign mag_lt_ba = fb[62:0] < fa[62:0];
  // Total order used by min/max: -0 sits below +0.
  assign a_below   = (fa[63] & ~fb[63]) | (~fa[63] & ~fb[63] & mag_lt_ab) |
                     (fa[63] & fb[63] & mag_lt_ba);
  assign feq       = ~any_nan & ((fa == fb) | both_zero);
  assign flt       = ~any_nan & ~both_zero & a_below;

  always_comb begin
    fresult = CANON_NAN;
    fflags  = 5'd0;
    case (funct3)
      OP_FADD, OP_FSUB: begin
        fresult = add_res.val;
        fflags  = add_res.flags;
      end
      OP_FMUL: begin
        fresult = mul_res.val;
        fflags  = mul_res.flags;
      end
      OP_FMIN, OP_FMAX: begin
        fflags[NV] = any_snan;
        if (ca.isnan && cb.isnan) fresult = CANON_NAN;
        else if (ca.isnan)        fresult = fb;
        else if (cb.isnan)        fresult = fa;
        else if (funct3 == OP_FMIN) fresult = a_below ? fa : fb;
        else                      fresult = a_below ? fb : fa;
      end
      OP_FEQ: begin
        fresult    = {63'd0, feq};
        fflags[NV] = any_snan;
      end
      OP_FLT: begin
        fresult    = {63'd0, flt};
        fflags[NV] = any_nan;
      end
      OP_FSGNJ: fresult = {fop2[63], fop1[62:0]};
      default:  fresult = CANON_NAN;
    endcase
    fflags[DZ] = 1'b0;
  end

endmodule

// File: rtl/rv64_fp_datapath.sv
// rtl/rv64_fp_datapath.sv - RV64F/D FP register file (32x64) with combinational binary64 FPU
module rv64_fp_datapath
  import fp_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int XLEN  = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fwrite_en,
  input  logic [4:0]      frs1,
  input  logic [4:0]      frs2,
  input  logic [4:0]      frd,
  input  logic [XLEN-1:0] fdata_in,
  output logic [XLEN-1:0] fdata_out1,
  output logic [XLEN-1:0] fdata_out2,
  input  logic [XLEN-1:0] fop1,
  input  logic [XLEN-1:0] fop2,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] fresult,
  output logic [4:0]      fflags
);

  logic [XLEN-1:0] fregs [NREGS];

  // f0 is a normal register; reads deliberately see the pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) fregs[i] <= '0;
    end else if (fwrite_en) begin
      fregs[frd] <= fdata_in;
    end
  end

  assign fdata_out1 = fregs[frs1];
  assign fdata_out2 = fregs[frs2];

  fp_dp_alu u_alu (
    .fop1    (fop1),
    .fop2    (fop2),
    .funct3  (funct3),
    .fresult (fresult),
    .fflags  (fflags)
  );

endmodule

// File: tb/tb_rv64_fp_datapath.sv
// tb/tb_rv64_fp_datapath.sv - self-checking bench: register file, directed FPU vectors, real-arithmetic model
module tb_rv64_fp_datapath;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam int NDIR = 34;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic [4:0]  f;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, fwrite_en;
  logic [4:0]  frs1, frs2, frd, fflags;
  logic [63:0] fdata_in, fdata_out1, fdata_out2, fop1, fop2, fresult;
  logic [2:0]  funct3;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] ref_regs [32];
  vec_t dir_tab [NDIR];

  rv64_fp_datapath dut (
    .clk(clk), .reset(reset), .fwrite_en(fwrite_en),
    .frs1(frs1), .frs2(frs2), .frd(frd), .fdata_in(fdata_in),
    .fdata_out1(fdata_out1), .fdata_out2(fdata_out2),
    .fop1(fop1), .fop2(fop2), .funct3(funct3),
    .fresult(fresult), .fflags(fflags)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] rand_num();
    logic [63:0] m;
    logic [10:0] e;
    m = {$urandom, $urandom};
    e = 11'(983 + $urandom_range(0, 80));
    return {m[63], e, m[51:0]};
  endfunction

  function automatic logic [63:0] rand_cmp();
    logic [63:0] m;
    m = {$urandom, $urandom};
    case ($urandom_range(0, 9))
      0:       return {m[63], 11'h7FF, 1'b1, m[50:0]};
      1:       return {m[63], 11'h7FF, 1'b0, m[50:1], 1'b1};
      2:       return {m[63], 63'd0};
      3:       return {m[63], 11'h7FF, 52'd0};
      default: return rand_num();
    endcase
  endfunction

  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  task automatic test_reset();
    reset = 1'b1; fwrite_en = 1'b0; frd = 5'd0; fdata_in = 64'd0;
    frs1 = 5'd0; frs2 = 5'd0;
    fop1 = 64'h3FF0_0000_0000_0000; fop2 = 64'h4000_0000_0000_0000; funct3 = 3'b000;
    #12;
    for (int i = 0; i < 32; i++) begin
      frs1 = 5'(i); frs2 = 5'(31 - i);
      #1;
      vectors++;
      if (fdata_out1 !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_port1 f%0d: got %h expected 0", i, fdata_out1);
      end
      vectors++;
      if (fdata_out2 !== 64'd0) begin
        miscompares++;
        $display("FAIL reset_port2 f%0d: got %h expected 0", 31 - i, fdata_out2);
      end
      ref_regs[i] = 64'd0;
    end
    vectors++;
    if (fresult !== 64'h4008_0000_0000_0000 || fflags !== 5'd0) begin
      miscompares++;
      $display("FAIL fpu_in_reset: got %h/%h expected 4008000000000000/00", fresult, fflags);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_regfile();
    logic [4:0]  wa, ra2;
    logic [63:0] wd;
    logic        we;
    for (int k = 0; k < 2; k++) begin
      wa = (k == 0) ? 5'd5 : 5'd0;
      wd = (k == 0) ? 64'h3FF0_0000_0000_0000 : 64'hDEAD_BEEF_CAFE_F00D;
      @(negedge clk);
      fwrite_en = 1'b1; frd = wa; fdata_in = wd; frs1 = wa; frs2 = wa;
      #1;
      vectors++;
      if (fdata_out1 !== ref_regs[wa]) begin
        miscompares++;
        $display("FAIL f%0d_same_cycle: got %h expected %h", wa, fdata_out1, ref_regs[wa]);
      end
      @(posedge clk); #1;
      ref_regs[wa] = wd;
      vectors++;
      if (fdata_out2 !== wd) begin
        miscompares++;
        $display("FAIL f%0d_after_edge: got %h expected %h", wa, fdata_out2, wd);
      end
    end
    for (int n = 0; n < 80; n++) begin
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom); ra2 = 5'($urandom); wd = {$urandom, $urandom};
      @(negedge clk);
      fwrite_en = we; frd = wa; fdata_in = wd; frs1 = wa; frs2 = ra2;
      #1;
      vectors++;
      if (fdata_out1 !== ref_regs[wa] || fdata_out2 !== ref_regs[ra2]) begin
        miscompares++;
        $display("FAIL rf_pre[%0d]: got %h,%h expected %h,%h", n, fdata_out1, fdata_out2,
                 ref_regs[wa], ref_regs[ra2]);
      end
      @(posedge clk); #1;
      if (we) ref_regs[wa] = wd;
      vectors++;
      if (fdata_out1 !== ref_regs[wa]) begin
        miscompares++;
        $display("FAIL rf_post[%0d] f%0d: got %h expected %h", n, wa, fdata_out1, ref_regs[wa]);
      end
    end
    @(negedge clk);
    fwrite_en = 1'b0;
  endtask

  task automatic test_fpu_directed();
    dir_tab = '{
      '{3'd0, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'h00},
      '{3'd0, 64'h3FF0000000000000, 64'h3C30000000000000, 64'h3FF0000000000000, 5'h01},
      '{3'd2, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 5'h05},
      '{3'd0, 64'h7FF0000000000000, 64'hFFF0000000000000, 64'h7FF8000000000000, 5'h10},
      '{3'd6, 64'h3FF0000000000000, 64'h4000000000000000, 64'h0000000000000001, 5'h00},
      '{3'd3, 64'h7FF8000000000000, 64'h4000000000000000, 64'h4000000000000000, 5'h00},
      '{3'd7, 64'h3FF0000000000000, 64'h8000000000000000, 64'hBFF0000000000000, 5'h00},
      '{3'd0, 64'h8000000000000000, 64'h8000000000000000, 64'h8000000000000000, 5'h00},
      '{3'd0, 64'h0000000000000000, 64'h8000000000000000, 64'h0000000000000000, 5'h00},
      '{3'd1, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 5'h00},
      '{3'd0, 64'h3FF0000000000000, 64'h0000000000000001, 64'h3FF0000000000000, 5'h00},
      '{3'd2, 64'h1A70000000000000, 64'h1A70000000000000, 64'h0000000000000000, 5'h03},
      '{3'd2, 64'h9A70000000000000, 64'h1A70000000000000, 64'h8000000000000000, 5'h03},
      '{3'd0, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'h10},
      '{3'd0, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'h00},
      '{3'd2, 64'h0000000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 5'h10},
      '{3'd2, 64'h7FF0000000000000, 64'hC000000000000000, 64'hFFF0000000000000, 5'h00},
      '{3'd5, 64'h7FF8000000000000, 64'h7FF8000000000000, 64'h0000000000000000, 5'h00},
      '{3'd5, 64'h7FF4000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 5'h10},
      '{3'd6, 64'h7FF8000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 5'h10},
      '{3'd5, 64'h8000000000000000, 64'h0000000000000000, 64'h0000000000000001, 5'h00},
      '{3'd3, 64'h0000000000000000, 64'h8000000000000000, 64'h8000000000000000, 5'h00},
      '{3'd4, 64'h8000000000000000, 64'h0000000000000000, 64'h0000000000000000, 5'h00},
      '{3'd3, 64'h7FF8000000000000, 64'hFFF8000000000000, 64'h7FF8000000000000, 5'h00},
      '{3'd3, 64'h7FF4000000000000, 64'h4000000000000000, 64'h4000000000000000, 5'h10},
      '{3'd0, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000, 5'h01},
      '{3'd0, 64'h3FF0000000000001, 64'h3CA0000000000000, 64'h3FF0000000000002, 5'h01},
      '{3'd1, 64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 5'h00},
      '{3'd0, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 5'h00},
      '{3'd1, 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 5'h10},
      '{3'd0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000, 5'h05},
      '{3'd4, 64'h3FF0000000000000, 64'hFFF0000000000000, 64'h3FF0000000000000, 5'h00},
      '{3'd6, 64'hBFF0000000000000, 64'h3FF0000000000000, 64'h0000000000000001, 5'h00},
      '{3'd6, 64'h0000000000000000, 64'h8000000000000000, 64'h0000000000000000, 5'h00}
    };
    for (int i = 0; i < NDIR; i++) begin
      fop1 = dir_tab[i].a; fop2 = dir_tab[i].b; funct3 = dir_tab[i].op;
      #1;
      vectors++;
      if (fresult !== dir_tab[i].r) begin
        miscompares++;
        $display("FAIL dir[%0d] result: got %h expected %h", i, fresult, dir_tab[i].r);
      end
      vectors++;
      if (fflags !== dir_tab[i].f) begin
        miscompares++;
        $display("FAIL dir[%0d] flags: got %h expected %h", i, fflags, dir_tab[i].f);
      end
    end
  endtask

  // Reference: host IEEE doubles (RNE) for values, TwoSum / significand width for NX.
  task automatic test_random_arith();
    logic [63:0]  a, b, er;
    logic [105:0] p;
    logic [4:0]   ef;
    real          ra, rb, s, bb, err;
    int           hi, lo;
    for (int n = 0; n < 600; n++) begin
      a = rand_num(); b = rand_num();
      ra = $bitstoreal(a); rb = $bitstoreal(b);
      ef = 5'd0;
      if (n % 3 == 2) begin
        s  = ra * rb;
        p  = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
        hi = 0; lo = 105;
        for (int i = 0; i < 106; i++) if (p[i]) hi = i;
        for (int i = 105; i >= 0; i--) if (p[i]) lo = i;
        ef[0] = (hi - lo + 1) > 53;
      end else begin
        if (n % 3 == 1) rb = -rb;
        s   = ra + rb;
        bb  = s - ra;
        err = (ra - (s - bb)) + (rb - bb);
        ef[0] = (err != 0.0);
      end
      er = $realtobits(s);
      fop1 = a; fop2 = b; funct3 = 3'(n % 3);
      #1;
      vectors++;
      if (fresult !== er || fflags !== ef) begin
        miscompares++;
        $display("FAIL arith[%0d] op%0d %h,%h: got %h/%h expected %h/%h", n, n % 3, a, b,
                 fresult, fflags, er, ef);
      end
    end
  endtask

  task automatic test_random_cmp();
    logic [63:0] a, b, er;
    logic [4:0]  ef;
    logic [2:0]  op;
    logic        an, bn, as, bs, is_min;
    real         ra, rb;
    for (int n = 0; n < 400; n++) begin
      a = rand_cmp();
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = {~a[63], a[62:0]};
        default: b = rand_cmp();
      endcase
      op = 3'(3 + (n % 4));
      an = is_nan(a); bn = is_nan(b);
      as = an && !a[51]; bs = bn && !b[51];
      ra = $bitstoreal(a); rb = $bitstoreal(b);
      ef = 5'd0; er = 64'd0;
      is_min = (op == 3'd3);
      if (op == 3'd3 || op == 3'd4) begin
        ef[4] = as | bs;
        if (an && bn)    er = QNAN;
        else if (an)     er = b;
        else if (bn)     er = a;
        else if (ra < rb) er = is_min ? a : b;
        else if (rb < ra) er = is_min ? b : a;
        else if (a[62:0] == 63'd0 && b[62:0] == 63'd0 && a[63] != b[63])
          er = (a[63] == is_min) ? a : b;
        else             er = a;
      end else if (op == 3'd5) begin
        ef[4] = as | bs;
        er = {63'd0, !(an || bn) && (ra == rb)};
      end else begin
        ef[4] = an | bn;
        er = {63'd0, !(an || bn) && (ra < rb)};
      end
      fop1 = a; fop2 = b; funct3 = op;
      #1;
      vectors++;
      if (fresult !== er || fflags !== ef) begin
        miscompares++;
        $display("FAIL cmp[%0d] op%0d %h,%h: got %h/%h expected %h/%h", n, op, a, b,
                 fresult, fflags, er, ef);
      end
    end
  endtask

  task automatic test_async_reset_mid_write();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      fwrite_en = 1'b1; frd = 5'(i); fdata_in = {$urandom, $urandom} | 64'd1;
    end
    @(negedge clk);
    fwrite_en = 1'b1; frd = 5'($urandom); fdata_in = {$urandom, $urandom} | 64'd1;
    #2 reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      frs1 = 5'(i); frs2 = 5'(i ^ 31);
      #1;
      vectors++;
      if (fdata_out1 !== 64'd0 || fdata_out2 !== 64'd0) begin
        miscompares++;
        $display("FAIL async_reset f%0d: got %h,%h expected 0,0", i, fdata_out1, fdata_out2);
      end
    end
    @(negedge clk);
    fwrite_en = 1'b0; reset = 1'b0; frs1 = 5'd7; frs2 = 5'd0;
    @(posedge clk); #1;
    vectors++;
    if (fdata_out1 !== 64'd0 || fdata_out2 !== 64'd0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h,%h expected 0,0", fdata_out1, fdata_out2);
    end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_fpu_directed();
    test_random_arith();
    test_random_cmp();
    test_async_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
